// File: rtl/video_timing_gen.sv
// Raster timing generator: hc/vc counters, timing swap only at frame wrap,
// ce-qualified decode register plus PIPE_STAGES delay stages on all video outputs.
module video_timing_gen #(
  parameter int CNT_WIDTH       = 12,
  parameter int PIPE_STAGES     = 0,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter logic [4*CNT_WIDTH-1:0] DEF_H =
    {CNT_WIDTH'(640), CNT_WIDTH'(16), CNT_WIDTH'(96), CNT_WIDTH'(48)},
  parameter logic [4*CNT_WIDTH-1:0] DEF_V =
    {CNT_WIDTH'(480), CNT_WIDTH'(10), CNT_WIDTH'(2), CNT_WIDTH'(33)},
  parameter logic [1:0] DEF_POL = 2'b00
) (
  input  logic                       clk_rgb,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic [4*CNT_WIDTH-1:0]     cfg_h,
  input  logic [4*CNT_WIDTH-1:0]     cfg_v,
  input  logic [1:0]                 cfg_pol,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic                       cfg_err,
  output logic [CNT_WIDTH-1:0]       x,
  output logic [CNT_WIDTH-1:0]       y,
  output logic                       hs,
  output logic                       vs,
  output logic                       de,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);
  localparam int W  = CNT_WIDTH;
  localparam int FW = FRAME_CNT_WIDTH;
  localparam int OW = 2*W + 5 + FW;
  localparam logic [W+1:0] MAX_TOT = (W+2)'(1) << W;
  localparam logic [OW-1:0] IDLE =
    {{(2*W+1){1'b0}}, ~DEF_POL[1], ~DEF_POL[0], {(FW+2){1'b0}}};

  function automatic logic [W+1:0] axis_total(input logic [4*W-1:0] t);
    return {2'b00, t[4*W-1:3*W]} + {2'b00, t[3*W-1:2*W]} +
           {2'b00, t[2*W-1:W]}   + {2'b00, t[W-1:0]};
  endfunction

  function automatic logic axis_ok(input logic [4*W-1:0] t);
    return (t[4*W-1:3*W] != '0) && (t[2*W-1:W] != '0) && (axis_total(t) <= MAX_TOT);
  endfunction

  // A total of exactly 2^W truncates to 0, so the subtraction still yields all ones.
  function automatic logic [W-1:0] axis_last(input logic [4*W-1:0] t);
    logic [W+1:0] tot;
    tot = axis_total(t);
    return tot[W-1:0] - W'(1);
  endfunction

  // Returns {in_active, in_sync, offset from end of back porch}.
  function automatic logic [W+1:0] axis_dec(input logic [W-1:0] c, input logic [4*W-1:0] t);
    logic [W+1:0] a_end, s_beg, c_x;
    c_x   = {2'b00, c};
    a_end = {2'b00, t[W-1:0]} + {2'b00, t[4*W-1:3*W]};
    s_beg = a_end + {2'b00, t[3*W-1:2*W]};
    return {(c >= t[W-1:0]) && (c_x < a_end), c_x >= s_beg, c - t[W-1:0]};
  endfunction

  logic [W-1:0]   hc_q, hc_d, vc_q, vc_d;
  logic [4*W-1:0] act_h_q, act_h_d, act_v_q, act_v_d;
  logic [4*W-1:0] pend_h_q, pend_h_d, pend_v_q, pend_v_d;
  logic [1:0]     pol_q, pol_d, pend_pol_q, pend_pol_d;
  logic           pend_vld_q, pend_vld_d, cfg_err_q, cfg_err_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic [OW-1:0]  pipe_q [PIPE_STAGES+1];

  logic          xfer, cfg_ok, h_wrap, v_wrap, frame_wrap;
  logic [W+1:0]  h_dec, v_dec;
  logic          de_c;
  logic [OW-1:0] dec_vec;

  assign cfg_ready = ~pend_vld_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    xfer       = cfg_valid && cfg_ready;
    cfg_ok     = axis_ok(cfg_h) && axis_ok(cfg_v);
    h_wrap     = (hc_q == axis_last(act_h_q));
    v_wrap     = (vc_q == axis_last(act_v_q));
    frame_wrap = ce && h_wrap && v_wrap;

    hc_d       = hc_q;
    vc_d       = vc_q;
    act_h_d    = act_h_q;
    act_v_d    = act_v_q;
    pol_d      = pol_q;
    pend_h_d   = pend_h_q;
    pend_v_d   = pend_v_q;
    pend_pol_d = pend_pol_q;
    pend_vld_d = pend_vld_q;
    fcnt_d     = fcnt_q;
    cfg_err_d  = xfer && !cfg_ok;

    if (ce) begin
      if (h_wrap) begin
        hc_d = '0;
        vc_d = v_wrap ? '0 : vc_q + W'(1);
      end else begin
        hc_d = hc_q + W'(1);
      end
    end
    if (frame_wrap) begin
      fcnt_d = fcnt_q + FW'(1);
      if (pend_vld_q) begin
        act_h_d    = pend_h_q;
        act_v_d    = pend_v_q;
        pol_d      = pend_pol_q;
        pend_vld_d = 1'b0;
      end
    end
    // Transfers only happen with nothing pending, so this never races the swap above.
    if (xfer && cfg_ok) begin
      pend_h_d   = cfg_h;
      pend_v_d   = cfg_v;
      pend_pol_d = cfg_pol;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    h_dec   = axis_dec(hc_q, act_h_q);
    v_dec   = axis_dec(vc_q, act_v_q);
    de_c    = h_dec[W+1] && v_dec[W+1];
    dec_vec = {de_c ? h_dec[W-1:0] : '0,
               de_c ? v_dec[W-1:0] : '0,
               de_c,
               h_dec[W] ? pol_q[1] : ~pol_q[1],
               v_dec[W] ? pol_q[0] : ~pol_q[0],
               hc_q == '0,
               (hc_q == '0) && (vc_q == '0),
               fcnt_q};
  end

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      hc_q       <= '0;
      vc_q       <= '0;
      act_h_q    <= DEF_H;
      act_v_q    <= DEF_V;
      pol_q      <= DEF_POL;
      pend_h_q   <= '0;
      pend_v_q   <= '0;
      pend_pol_q <= '0;
      pend_vld_q <= 1'b0;
      fcnt_q     <= '0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i <= PIPE_STAGES; i++) pipe_q[i] <= IDLE;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      act_h_q    <= act_h_d;
      act_v_q    <= act_v_d;
      pol_q      <= pol_d;
      pend_h_q   <= pend_h_d;
      pend_v_q   <= pend_v_d;
      pend_pol_q <= pend_pol_d;
      pend_vld_q <= pend_vld_d;
      fcnt_q     <= fcnt_d;
      cfg_err_q  <= cfg_err_d;
      if (ce) begin
        pipe_q[0] <= dec_vec;
        for (int i = PIPE_STAGES; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign {x, y, de, hs, vs, line_start, frame_start, frame_cnt} = pipe_q[PIPE_STAGES];

endmodule
